// File: rtl/n64_vbus_demux_pkg.sv
// Shared constants and types for the N64 video bus demultiplexer.
// Holds bus widths, the PAL threshold, FSM encoding and sync-nibble bit positions.
package n64_vbus_demux_pkg;

  localparam int COLOR_W = 7;
  localparam int SYNC_W  = 4;
  localparam int LCNT_W  = 10;

  localparam logic [LCNT_W-1:0] PAL_LINE_THRES = 10'd288;

  // Sync nibble layout {VSYNC,CLAMP,HSYNC,CSYNC}, all active-low
  localparam int VSYNC_BIT = 3;
  localparam int HSYNC_BIT = 1;

  localparam logic [SYNC_W-1:0] SYNC_IDLE = 4'hF;

  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_GET_R = 2'd1;
  localparam logic [1:0] ST_GET_G = 2'd2;
  localparam logic [1:0] ST_GET_B = 2'd3;

  typedef struct packed {
    logic [SYNC_W-1:0]  sync;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } pixel_t;

endpackage

// File: rtl/n64_vmode_detect.sv
// PAL/NTSC and progressive/interlaced detection from the line count per field.
// Fed only with accepted sync nibbles; edges are judged between consecutive nibbles.
module n64_vmode_detect
  import n64_vbus_demux_pkg::*;
(
  input  logic VCLK,
  input  logic VRST,
  input  logic nib_stb_i,
  input  logic nhsync_i,
  input  logic nvsync_i,
  output logic palmode_o,
  output logic n64_480i_o,
  output logic vmode_upd_o
);

  logic              nhsync_q, nvsync_q;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic [LCNT_W-1:0] lcnt_prev_q, lcnt_prev_d;
  logic              pal_q, pal_d;
  logic              i480_q, i480_d;
  logic              upd_q, upd_d;
  logic              hs_fall, vs_fall;

  assign hs_fall = nib_stb_i & nhsync_q & ~nhsync_i;
  assign vs_fall = nib_stb_i & nvsync_q & ~nvsync_i;

  always_comb begin
    lcnt_d      = lcnt_q;
    lcnt_prev_d = lcnt_prev_q;
    pal_d       = pal_q;
    i480_d      = i480_q;
    upd_d       = 1'b0;
    // A coincident HSYNC fall is ignored: the field is judged on the pre-increment count
    if (vs_fall) begin
      pal_d       = (lcnt_q > PAL_LINE_THRES);
      i480_d      = (lcnt_q != lcnt_prev_q);
      lcnt_prev_d = lcnt_q;
      lcnt_d      = '0;
      upd_d       = 1'b1;
    end else if (hs_fall && (lcnt_q != '1)) begin
      lcnt_d = lcnt_q + 1'b1;
    end
  end

  // Previous-level registers clear to 0 so the first nibble after reset never forms an edge
  always_ff @(posedge VCLK) begin
    if (VRST) begin
      nhsync_q    <= 1'b0;
      nvsync_q    <= 1'b0;
      lcnt_q      <= '0;
      lcnt_prev_q <= '0;
      pal_q       <= 1'b0;
      i480_q      <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      if (nib_stb_i) begin
        nhsync_q <= nhsync_i;
        nvsync_q <= nvsync_i;
      end
      lcnt_q      <= lcnt_d;
      lcnt_prev_q <= lcnt_prev_d;
      pal_q       <= pal_d;
      i480_q      <= i480_d;
      upd_q       <= upd_d;
    end
  end

  assign palmode_o   = pal_q;
  assign n64_480i_o  = i480_q;
  assign vmode_upd_o = upd_q;

endmodule

// File: rtl/n64_vbus_demux.sv
// Demultiplexes the 4-phase N64 video bus (sync, R, G, B) into one pixel word per pixel.
// Optional VDEMUX_ERRCNT_EN adds perr_cnt_o, a saturating count of aborted partial pixels.
module n64_vbus_demux
  import n64_vbus_demux_pkg::*;
(
  input  logic               VCLK,
  input  logic               VRST,
  input  logic               nVDSYNC,
  input  logic [COLOR_W-1:0] VD_i,
  output logic               vdata_valid_o,
  output logic [SYNC_W-1:0]  vsync_o,
  output logic [COLOR_W-1:0] R_o,
  output logic [COLOR_W-1:0] G_o,
  output logic [COLOR_W-1:0] B_o,
  output logic               palmode_o,
  output logic               n64_480i_o,
  output logic               vmode_upd_o
`ifdef VDEMUX_ERRCNT_EN
  ,
  output logic [7:0]         perr_cnt_o
`endif
);

  logic [1:0] state_q, state_d;
  pixel_t     shadow_q, shadow_d;
  pixel_t     pix_q;
  logic       pend_q, pend_d;
  logic       valid_q;
  logic       sync_stb;

  assign sync_stb = ~nVDSYNC;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    state_d  = state_q;
    shadow_d = shadow_q;
    pend_d   = 1'b0;
    if (!nVDSYNC) begin
      shadow_d.sync = VD_i[SYNC_W-1:0];
      state_d       = ST_GET_R;
    end else begin
      case (state_q)
        ST_GET_R: begin
          shadow_d.r = VD_i;
          state_d    = ST_GET_G;
        end
        ST_GET_G: begin
          shadow_d.g = VD_i;
          state_d    = ST_GET_B;
        end
        ST_GET_B: begin
          shadow_d.b = VD_i;
          state_d    = ST_WAIT;
          pend_d     = 1'b1;
        end
        default: state_d = ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge VCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (VRST) begin
      state_q <= ST_WAIT;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      pix_q   <= '{sync: SYNC_IDLE, r: '0, g: '0, b: '0};
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      valid_q <= pend_q;
      if (pend_q) pix_q <= shadow_q;
    end
  end

  // NOTE: the shadow needs no reset; it only reaches the outputs after all four phases were latched.
  always_ff @(posedge VCLK) begin
    shadow_q <= shadow_d;
  end

  assign vdata_valid_o = valid_q;
  assign vsync_o       = pix_q.sync;
  assign R_o           = pix_q.r;
  assign G_o           = pix_q.g;
  assign B_o           = pix_q.b;

  n64_vmode_detect u_vmode_detect (
    .VCLK        (VCLK),
    .VRST        (VRST),
    .nib_stb_i   (sync_stb),
    .nhsync_i    (VD_i[HSYNC_BIT]),
    .nvsync_i    (VD_i[VSYNC_BIT]),
    .palmode_o   (palmode_o),
    .n64_480i_o  (n64_480i_o),
    .vmode_upd_o (vmode_upd_o)
  );

`ifdef VDEMUX_ERRCNT_EN
  logic [7:0] perr_cnt_q;
  logic       drop_partial;

  // A sync in GET_B is not counted: R and G arrived, only B was missing
  assign drop_partial = sync_stb & ((state_q == ST_GET_R) | (state_q == ST_GET_G));

  always_ff @(posedge VCLK) begin
    if (VRST) begin
      perr_cnt_q <= '0;
    end else if (drop_partial && (perr_cnt_q != 8'hFF)) begin
      perr_cnt_q <= perr_cnt_q + 8'd1;
    end
  end

  assign perr_cnt_o = perr_cnt_q;
`endif

endmodule
